// File: rtl/mvau_pkg.sv
// mvau_pkg: shared defaults and result-width helper for the XNOR MVU PE (see MVU_XNOR_BIPOLAR_EN).
package mvau_pkg;
  localparam int SIMD_DEF = 16;
  localparam int SF_DEF = 4;
  localparam int TDSTI_DEF = 16;
  function automatic int result_width(int simd, int sf, bit bipolar);
    return $clog2(simd * sf + 1) + (bipolar ? 1 : 0);
  endfunction
endpackage

// File: rtl/mvu_popcount.sv
// mvu_popcount: combinational popcount built as a recursive binary adder tree.
module mvu_popcount #(
  parameter int SIMD = 16
) (
  input  logic [SIMD-1:0]              v,
  output logic [$clog2(SIMD+1)-1:0]    cnt
);
  localparam int PW = $clog2(SIMD + 1);
  if (SIMD == 1) begin : g_leaf
    assign cnt = v;
  end else begin : g_node
    localparam int L = SIMD / 2;
    localparam int R = SIMD - L;
    logic [$clog2(L+1)-1:0] a;
    logic [$clog2(R+1)-1:0] b;
    mvu_popcount #(.SIMD(L)) u_l (.v(v[L-1:0]), .cnt(a));
    mvu_popcount #(.SIMD(R)) u_r (.v(v[SIMD-1:L]), .cnt(b));
    assign cnt = PW'(a) + PW'(b);
  end
endmodule

// File: rtl/mvu_pe_xnor_acc.sv
// mvu_pe_xnor_acc: 2-stage XNOR/popcount fold accumulator with valid/ready handshake.
// Define MVU_XNOR_BIPOLAR_EN for signed bipolar output 2*sum - SIMD*SF.
module mvu_pe_xnor_acc
  import mvau_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int SF    = SF_DEF,
  parameter int TDstI = TDSTI_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [SIMD-1:0]  in_act,
  input  logic [SIMD-1:0]  in_wgt,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [TDstI-1:0] out
);
`ifdef MVU_XNOR_BIPOLAR_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif
  localparam int AW = result_width(SIMD, SF, 1'b0);
  localparam int PW = $clog2(SIMD + 1);
  localparam int CW = SF > 1 ? $clog2(SF) : 1;
  if (TDstI < result_width(SIMD, SF, BIP)) begin : g_width_chk
    $error("mvu_pe_xnor_acc: TDstI too narrow for SIMD*SF result");
  end
  logic            stall, accept, s1_v, s1_last, cnt_last;
  logic [SIMD-1:0] s1_vec;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc, sum;
  logic [PW-1:0]   pop;
  logic [TDstI-1:0] res;
  assign stall    = out_v && !out_rdy;
  assign in_rdy   = !stall;
  assign accept   = in_v && in_rdy;
  assign cnt_last = cnt == CW'(SF - 1);
  mvu_popcount #(.SIMD(SIMD)) u_pop (.v(s1_vec), .cnt(pop));
  assign sum = acc + AW'(pop);
`ifdef MVU_XNOR_BIPOLAR_EN
  assign res = TDstI'({sum, 1'b0}) - TDstI'(SIMD * SF);
`else
  assign res = TDstI'(sum);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_vec  <= '0;
      cnt     <= '0;
      acc     <= '0;
      out_v   <= 1'b0;
      out     <= '0;
    end else if (!stall) begin
      s1_v  <= accept;
      out_v <= s1_v && s1_last;
      if (accept) begin
        s1_vec  <= in_act ~^ in_wgt;
        s1_last <= cnt_last;
        cnt     <= cnt_last ? '0 : cnt + 1'b1;
      end
      if (s1_v) begin
        acc <= s1_last ? '0 : sum;
        if (s1_last) out <= res;
      end
    end
  end
endmodule

// File: tb/tb_mvu_pe_xnor_acc.sv
// tb_mvu_pe_xnor_acc: directed self-checking bench, SIMD=4 with SF=2 and SF=1 instances.
module tb_mvu_pe_xnor_acc;
`ifdef MVU_XNOR_BIPOLAR_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_v, in_rdy, out_v, out_rdy;
  logic [3:0] in_act, in_wgt;
  logic [15:0] out;
  logic in_v1, in_rdy1, out_v1;
  logic [3:0] act1, wgt1;
  logic [15:0] out1;
  int n_cmp = 0, n_bad = 0;
  mvu_pe_xnor_acc #(.SIMD(4), .SF(2), .TDstI(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy), .in_act(in_act), .in_wgt(in_wgt),
    .out_v(out_v), .out_rdy(out_rdy), .out(out)
  );
  mvu_pe_xnor_acc #(.SIMD(4), .SF(1), .TDstI(16)) u_sf1 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v1), .in_rdy(in_rdy1), .in_act(act1), .in_wgt(wgt1),
    .out_v(out_v1), .out_rdy(1'b1), .out(out1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] expv(int s, int n);
    return BIP ? 16'(2 * s - n) : 16'(s);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fold(input string tag, input logic [3:0] a0, input logic [3:0] w0,
                      input logic [3:0] a1, input logic [3:0] w1, input int gap, input int s);
    int k;
    in_v = 1'b1; in_act = a0; in_wgt = w0;
    step();
    in_v = 1'b0;
    repeat (gap) step();
    in_v = 1'b1; in_act = a1; in_wgt = w1;
    step();
    in_v = 1'b0;
    k = 0;
    while (!out_v && k < 6) begin
      step();
      k++;
    end
    check({tag, "_lat"}, k, 1);
    check(tag, out, expv(s, 8));
    step();
    check({tag, "_drop"}, out_v, 1'b0);
  endtask
  initial begin
    int exp1[10];
    rst_n = 1'b0; in_v = 1'b0; in_act = '0; in_wgt = '0; out_rdy = 1'b1;
    in_v1 = 1'b0; act1 = '0; wgt1 = '0;
    step();
    step();
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_v", out_v, 1'b0);
    check("rst_out", out, 16'd0);
    check("rst_out_v1", out_v1, 1'b0);
    rst_n = 1'b1;
    fold("match", 4'b1010, 4'b1010, 4'b1010, 4'b1010, 0, 8);
    fold("nomatch", 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    fold("mixed", 4'b1100, 4'b1010, 4'b1100, 4'b1010, 0, 4);
    out_rdy = 1'b0;
    in_v = 1'b1; in_act = 4'b1111; in_wgt = 4'b1111;
    step();
    step();
    in_v = 1'b0;
    step();
    check("stall_v", out_v, 1'b1);
    check("stall_res", out, expv(8, 8));
    in_v = 1'b1; in_act = 4'b1010; in_wgt = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      check("stall_rdy", in_rdy, 1'b0);
      check("stall_hold", out, expv(8, 8));
      step();
    end
    check("stall_hold_end", out, expv(8, 8));
    out_rdy = 1'b1;
    fold("stall_next", 4'b1010, 4'b0101, 4'b0111, 4'b0111, 0, 4);
    in_v = 1'b1; in_act = 4'b1111; in_wgt = 4'b1111;
    step();
    in_v = 1'b0; rst_n = 1'b0;
    step();
    check("midrst_out_v", out_v, 1'b0);
    check("midrst_out", out, 16'd0);
    check("midrst_rdy", in_rdy, 1'b1);
    rst_n = 1'b1;
    fold("rst_next", 4'b1100, 4'b1010, 4'b1100, 4'b1010, 0, 4);
    fold("gap0", 4'b1100, 4'b1010, 4'b1111, 4'b1111, 0, 6);
    fold("gap2", 4'b1100, 4'b1010, 4'b1111, 4'b1111, 2, 6);
    in_v1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      act1 = 4'($urandom);
      wgt1 = 4'($urandom);
      exp1[i] = $countones(~(act1 ^ wgt1));
      step();
      if (i == 0) check("sf1_first_v", out_v1, 1'b0);
      else begin
        check("sf1_v", out_v1, 1'b1);
        check("sf1_out", out1, expv(exp1[i-1], 4));
      end
    end
    in_v1 = 1'b0;
    step();
    check("sf1_last_v", out_v1, 1'b1);
    check("sf1_last", out1, expv(exp1[9], 4));
    step();
    check("sf1_drop", out_v1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mvu_pe_xnor_acc.md
MVU_PE_XNOR_ACC -- requirements
Module: mvu_pe_xnor_acc

Interface
REQ-001 SHALL have parameter SIMD, default 16: number of 1-bit XNOR lanes per beat.
REQ-002 SHALL have parameter SF, default 4: synapse fold, i.e. accepted beats per output.
REQ-003 SHALL have parameter TDstI, default 16: output word length.
REQ-004 SHALL have port clk, input, 1: clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_v, input, 1: input beat valid.
REQ-007 SHALL have port in_rdy, output, 1: block can accept a beat.
REQ-008 SHALL have port in_act, input, SIMD: activation bits, lane i = bit i.
REQ-009 SHALL have port in_wgt, input, SIMD: weight bits, lane i = bit i.
REQ-010 SHALL have port out_v, output, 1: out holds a completed fold result.
REQ-011 SHALL have port out_rdy, input, 1: downstream accepts out.
REQ-012 SHALL have port out, output, TDstI: accumulated result.

Function
REQ-013 SHALL accept a beat on any rising edge where in_v && in_rdy are both high.
REQ-014 SHALL compute per-lane product as in_act[i] XNOR in_wgt[i] and register the SIMD-bit product vector, plus a last flag, on the accept edge (stage 1).
REQ-015 SHALL derive a stall as out_v && !out_rdy; in_rdy = !stall; while stalled, no pipeline, counter or accumulator register changes.
REQ-016 SHALL keep a fold counter 0..SF-1, incremented per accepted beat and wrapping to 0 after SF-1; last flag = (count == SF-1); SF=1 makes every beat last.
REQ-017 SHALL at stage 2 popcount the stage-1 vector (range 0..SIMD) and, for a non-last beat, set acc <= acc + pop.
REQ-018 SHALL for a last beat set out <= acc + pop, acc <= 0 and out_v <= 1 in the same edge.
REQ-019 SHALL clear out_v on an edge with out_rdy high unless a new last beat completes in that edge; back-to-back results at 1 per cycle SHALL be sustained when SF=1 and out_rdy=1.
REQ-020 SHALL have latency of exactly 2 edges from acceptance of the last beat to out_v high; in_v gaps insert bubbles only and lose no state.
REQ-021 SHALL hold out stable while out_v && !out_rdy.
REQ-022 SHALL size the unipolar result as unsigned with width >= clog2(SIMD*SF+1); TDstI SHALL be checked by an elaboration-time assertion and never truncated silently.

Reset
REQ-023 SHALL, on rst_n low at a clock edge, clear fold counter, acc, stage-1 valid/vector, out_v and out to 0.
REQ-024 SHALL discard any partial fold on reset mid-operation; the first beat accepted after reset starts a new fold at count 0.
REQ-025 SHALL drive in_rdy high during and immediately after reset, since out_v = 0.

Configuration
REQ-026 SHALL, with MVU_XNOR_BIPOLAR_EN defined, output signed two's complement 2*sum - SIMD*SF, range -SIMD*SF..+SIMD*SF, with TDstI >= clog2(SIMD*SF+1)+1 asserted.
REQ-027 SHALL, without MVU_XNOR_BIPOLAR_EN, output the unsigned popcount sum.
REQ-028 SHALL not change latency or handshake with MVU_XNOR_BIPOLAR_EN.

Structure
REQ-029 SHALL place the default SIMD/SF/TDstI constants and the width helper (result-width function) in the shared package mvau_pkg.
REQ-030 SHALL implement the popcount as sub-module mvu_popcount (parameter SIMD, combinational adder tree, output width clog2(SIMD+1)).
REQ-031 SHALL contain, in the top: handshake, stage-1 register, fold counter, accumulator and output register.

Verification
Parameters for all scenarios SIMD=4, SF=2 unless stated.
REQ-032 SHALL check: beats act=4'b1010/wgt=4'b1010 twice, out_rdy=1 -> out=8 (bipolar 8), out_v high 2 edges after second accept, for 1 cycle.
REQ-033 SHALL check: beats act=4'b1111/wgt=4'b0000 twice -> out=0 (bipolar -8); then act=4'b1100/wgt=4'b1010 twice -> out=4 (bipolar 0), acc cleared between folds.
REQ-034 SHALL check: out_rdy low for 3 cycles with in_v high -> out held, in_rdy low, no beat lost; the following fold result is correct.
REQ-035 SHALL check: rst_n pulsed low after 1 beat of a fold -> out_v=0, out=0; the next 2 beats alone form the result.
REQ-036 SHALL check: SF=1, continuous in_v with random data, out_rdy=1 -> one result per cycle, each equal to popcount(~(act^wgt)) of the beat 2 edges earlier.
REQ-037 SHALL check: in_v toggled 1,0,0,1 -> result identical to the gap-free case.
